trap_controller: RTL and testbench
==================================

Name: trap_controller

Overview:
- Central exception sequencer; it drives the system register file's capture, supervisor-entry and supervisor-exit inputs.
- Arbitrates iTLB and dTLB miss requests and IRET requests from the pipeline.
- Produces the one-cycle capture pulses and fault data that the system register file latches.
- Flushes the pipeline, then redirects fetch to the handler vector on a trap, or to the saved EPC on IRET.

Parameters:
- HANDLER_VEC, 32'h0000_2000, fetch address of the TLB-miss handler.
- FLUSH_CYCLES, 3, number of cycles flush is held asserted (legal range 1..15).

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- itlb_miss  in  1  fetch-stage translation miss (level, sampled in IDLE only)
- itlb_vaddr  in  32  faulting fetch virtual address
- if_pc  in  32  PC of the fetch-stage instruction
- dtlb_miss  in  1  memory-stage translation miss
- dtlb_vaddr  in  32  faulting data virtual address
- mem_pc  in  32  PC of the memory-stage instruction
- iret_req  in  1  decoded IRET in decode stage
- epc_in  in  32  current system register 0 (saved PC)
- supervisor_mode  in  1  current privilege bit from system register file
- tlb_miss  out  1  one-cycle capture pulse to system register file
- tlb_pc  out  32  PC to capture into system register 0
- tlb_addr  out  32  faulting address to capture into system register 1
- iret  out  1  one-cycle pulse clearing supervisor mode
- flush  out  1  kill all in-flight pipeline stages
- pc_redirect  out  1  one-cycle fetch redirect strobe
- pc_redirect_target  out  32  redirect address, valid while pc_redirect=1
- busy  out  1  high in every state except IDLE
- halted  out  1  double-fault indication, sticky until reset

Behaviour:
- All outputs are registered. On reset all outputs are 0, including tlb_pc, tlb_addr and pc_redirect_target, and the FSM enters IDLE. Reset in any state aborts the sequence immediately; no pulse is emitted afterwards.
- FSM states: IDLE, TRAP_FLUSH, IRET_FLUSH, REDIRECT, HALT. A 4-bit down-counter cnt times the flush states.
- IDLE arbitration at cycle T, in priority order; the older instruction wins:
  - dtlb_miss: source is {mem_pc, dtlb_vaddr}.
  - iret_req: only when supervisor_mode=1; with supervisor_mode=0 it is ignored entirely.
  - itlb_miss: source is {if_pc, itlb_vaddr}.
  - The losing requests are dropped; the flush kills them.
- Trap in IDLE with supervisor_mode=0:
  - At T+1: tlb_miss=1 for exactly one cycle, tlb_pc/tlb_addr hold the selected source, flush=1. The FSM goes to TRAP_FLUSH with cnt=FLUSH_CYCLES-1.
  - flush stays 1 for FLUSH_CYCLES cycles total (T+1 .. T+FLUSH_CYCLES).
  - At T+FLUSH_CYCLES+1 (REDIRECT): flush=0, pc_redirect=1 for one cycle, pc_redirect_target=HANDLER_VEC. The next cycle returns to IDLE.
  - tlb_pc and tlb_addr hold their values until the next trap.
- Trap in IDLE with supervisor_mode=1 (double fault):
  - At T+1: HALT, halted=1, flush=1 held permanently.
  - No tlb_miss pulse and no redirect. Only reset exits HALT.
- IRET in IDLE:
  - epc_in is captured at T.
  - At T+1: iret=1 for one cycle, flush=1. The FSM goes to IRET_FLUSH with the same FLUSH_CYCLES timing.
  - REDIRECT then issues pc_redirect=1 with target = the epc captured at T. Changes to epc_in after T have no effect.
- All requests arriving while busy=1 are ignored; they are not queued.
- tlb_miss and iret are never both 1 in the same cycle.
- With FLUSH_CYCLES=1, flush is high for exactly one cycle and REDIRECT follows immediately.
- Total trap or IRET latency, from request sample to redirect strobe, is FLUSH_CYCLES+1 cycles.

Test Plan:
1. dtlb_miss=1, mem_pc=32'h0000_0410, dtlb_vaddr=32'h8000_0ABC, supervisor_mode=0 at cycle 10 -> tlb_miss pulse at 11 with tlb_pc=0x410 and tlb_addr=0x8000_0ABC; flush high on 11–13; pc_redirect at 14 with target 0x2000; busy low from 15.
2. dtlb_miss, itlb_miss and iret_req all asserted together, supervisor_mode=0 -> dtlb source captured; no iret pulse. Repeat with only itlb_miss and iret_req, supervisor_mode=1 -> IRET path taken; no tlb_miss pulse.
3. iret_req=1, supervisor_mode=1, epc_in=32'h0000_0104 at cycle 20; epc_in changed to 0xFFFF_FFFF at 21 -> iret pulse at 21; flush on 21–23; redirect at 24 with target 0x104.
4. itlb_miss with supervisor_mode=1 -> halted=1 and flush=1 held for 50+ cycles; tlb_miss, iret and pc_redirect never assert; reset clears all outputs to 0.
5. dtlb_miss asserted again on cycles 12 and 13 during a trap sequence -> ignored: exactly one tlb_miss pulse and one redirect. iret_req with supervisor_mode=0 -> no activity, busy stays 0.
6. reset asserted at cycle 12, mid-TRAP_FLUSH -> at 13 all outputs are 0 and the FSM is IDLE; no redirect ever issues; a fresh trap afterwards completes with normal timing.

Source files
------------

// File: rtl/trap_controller.sv
// Exception sequencer: arbitrates TLB misses and IRET, pulses the system register
// file capture strobes, flushes the pipeline and redirects fetch.
module trap_controller #(
    parameter logic [31:0] HANDLER_VEC  = 32'h0000_2000,
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        itlb_miss,
    input  logic [31:0] itlb_vaddr,
    input  logic [31:0] if_pc,
    input  logic        dtlb_miss,
    input  logic [31:0] dtlb_vaddr,
    input  logic [31:0] mem_pc,
    input  logic        iret_req,
    input  logic [31:0] epc_in,
    input  logic        supervisor_mode,
    output logic        tlb_miss,
    output logic [31:0] tlb_pc,
    output logic [31:0] tlb_addr,
    output logic        iret,
    output logic        flush,
    output logic        pc_redirect,
    output logic [31:0] pc_redirect_target,
    output logic        busy,
    output logic        halted,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TRAP_FLUSH = 3'd1,
        S_IRET_FLUSH = 3'd2,
        S_REDIRECT   = 3'd3,
        S_HALT       = 3'd4
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] epc_q;
    logic        tlb_miss_q, iret_q, flush_q, pc_redirect_q, busy_q, halted_q;
    logic [31:0] tlb_pc_q, tlb_addr_q, target_q;

    // Requests are plain levels with no ready handshake: they are sampled only in
    // IDLE (busy=0); anything raised while busy=1 is dropped, never queued.
    logic        req_trap, req_iret;
    logic [31:0] src_pc, src_addr;

    always_comb begin
        req_trap = 1'b0;
        req_iret = 1'b0;
        src_pc   = if_pc;
        src_addr = itlb_vaddr;
        if (dtlb_miss) begin
            req_trap = 1'b1;
            src_pc   = mem_pc;
            src_addr = dtlb_vaddr;
        end else if (iret_req && supervisor_mode) begin
            req_iret = 1'b1;
        end else if (itlb_miss) begin
            req_trap = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 4'd0;
            epc_q         <= 32'd0;
            tlb_miss_q    <= 1'b0;
            iret_q        <= 1'b0;
            flush_q       <= 1'b0;
            pc_redirect_q <= 1'b0;
            busy_q        <= 1'b0;
            halted_q      <= 1'b0;
            tlb_pc_q      <= 32'd0;
            tlb_addr_q    <= 32'd0;
            target_q      <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tlb_miss_q    <= 1'b0;
                    iret_q        <= 1'b0;
                    flush_q       <= 1'b0;
                    pc_redirect_q <= 1'b0;
                    busy_q        <= 1'b0;
                    if (req_trap && supervisor_mode) begin
                        // Fault while already in the handler: park forever.
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        flush_q  <= 1'b1;
                        busy_q   <= 1'b1;
                    end else if (req_trap) begin
                        state_q    <= S_TRAP_FLUSH;
                        cnt_q      <= CNT_INIT;
                        tlb_miss_q <= 1'b1;
                        tlb_pc_q   <= src_pc;
                        tlb_addr_q <= src_addr;
                        flush_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (req_iret) begin
                        state_q <= S_IRET_FLUSH;
                        cnt_q   <= CNT_INIT;
                        epc_q   <= epc_in;
                        iret_q  <= 1'b1;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                S_TRAP_FLUSH, S_IRET_FLUSH: begin
                    tlb_miss_q <= 1'b0;
                    iret_q     <= 1'b0;
                    if (cnt_q == 4'd0) begin
                        state_q       <= S_REDIRECT;
                        flush_q       <= 1'b0;
                        pc_redirect_q <= 1'b1;
                        target_q      <= (state_q == S_TRAP_FLUSH) ? HANDLER_VEC : epc_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_REDIRECT: begin
                    state_q       <= S_IDLE;
                    pc_redirect_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                    flush_q  <= 1'b1;
                    busy_q   <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tlb_miss           = tlb_miss_q;
    assign tlb_pc             = tlb_pc_q;
    assign tlb_addr           = tlb_addr_q;
    assign iret               = iret_q;
    assign flush              = flush_q;
    assign pc_redirect        = pc_redirect_q;
    assign pc_redirect_target = target_q;
    assign busy               = busy_q;
    assign halted             = halted_q;
    assign dbg_state          = state_q;
endmodule

// File: tb/tb_trap_controller.sv
// Bench for trap_controller: directed vector table, hand sequences for the
// multi-cycle corners, then randomized traffic against a timeline reference model.
module tb_trap_controller;
    localparam int          F   = 3;
    localparam logic [31:0] H   = 32'h0000_2000;
    localparam logic [31:0] H1  = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, itlb_miss, dtlb_miss, iret_req, supervisor_mode;
    logic [31:0] itlb_vaddr, if_pc, dtlb_vaddr, mem_pc, epc_in;
    logic        tlb_miss, iret, flush, pc_redirect, busy, halted;
    logic [31:0] tlb_pc, tlb_addr, pc_redirect_target;
    logic [2:0]  dbg_state;
    logic        d1_tlb_miss, d1_iret, d1_flush, d1_pc_redirect, d1_busy, d1_halted;
    logic [31:0] d1_tlb_pc, d1_tlb_addr, d1_target;
    logic [2:0]  d1_dbg_state;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    trap_controller dut (
        .clk(clk), .reset(reset), .itlb_miss(itlb_miss), .itlb_vaddr(itlb_vaddr), .if_pc(if_pc),
        .dtlb_miss(dtlb_miss), .dtlb_vaddr(dtlb_vaddr), .mem_pc(mem_pc), .iret_req(iret_req),
        .epc_in(epc_in), .supervisor_mode(supervisor_mode), .tlb_miss(tlb_miss), .tlb_pc(tlb_pc),
        .tlb_addr(tlb_addr), .iret(iret), .flush(flush), .pc_redirect(pc_redirect),
        .pc_redirect_target(pc_redirect_target), .busy(busy), .halted(halted), .dbg_state(dbg_state)
    );

    trap_controller #(.HANDLER_VEC(H1), .FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .itlb_miss(itlb_miss), .itlb_vaddr(itlb_vaddr), .if_pc(if_pc),
        .dtlb_miss(dtlb_miss), .dtlb_vaddr(dtlb_vaddr), .mem_pc(mem_pc), .iret_req(iret_req),
        .epc_in(epc_in), .supervisor_mode(supervisor_mode), .tlb_miss(d1_tlb_miss), .tlb_pc(d1_tlb_pc),
        .tlb_addr(d1_tlb_addr), .iret(d1_iret), .flush(d1_flush), .pc_redirect(d1_pc_redirect),
        .pc_redirect_target(d1_target), .busy(d1_busy), .halted(d1_halted), .dbg_state(d1_dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst, dm, im, ir, sup;
        logic [31:0] mpc, dva, ipc, iva, epc;
        logic        e_tm, e_ir, e_fl, e_rd, e_bz, e_ht;
        logic [31:0] e_pc, e_addr, e_tgt;
    } vec_t;

    function automatic vec_t mk(input logic rst, dm, im, ir, sup,
                                input logic [31:0] mpc, dva, ipc, iva, epc,
                                input logic tm, irt, fl, rd, bz, ht,
                                input logic [31:0] pc, addr, tgt);
        vec_t v;
        v.rst = rst; v.dm = dm; v.im = im; v.ir = ir; v.sup = sup;
        v.mpc = mpc; v.dva = dva; v.ipc = ipc; v.iva = iva; v.epc = epc;
        v.e_tm = tm; v.e_ir = irt; v.e_fl = fl; v.e_rd = rd; v.e_bz = bz; v.e_ht = ht;
        v.e_pc = pc; v.e_addr = addr; v.e_tgt = tgt;
        return v;
    endfunction

    task automatic drive(input logic rst, dm, im, ir, sup, input logic [31:0] mpc, dva, ipc, iva, epc);
        reset = rst; dtlb_miss = dm; itlb_miss = im; iret_req = ir; supervisor_mode = sup;
        mem_pc = mpc; dtlb_vaddr = dva; if_pc = ipc; itlb_vaddr = iva; epc_in = epc;
    endtask

    // ---------------- reference model ----------------
    // A request accepted at edge 0 defines a timeline: capture pulse at offset 1,
    // flush for offsets 1..F, redirect at F+1, idle again from F+2.
    bit          m_active, m_halt, m_is_iret;
    int          m_k;
    logic [31:0] m_pc, m_addr, m_tgt;

    task automatic model_step();
        bit trap, take_iret;
        logic [31:0] spc, saddr;
        if (reset) begin
            m_active = 0; m_halt = 0; m_is_iret = 0; m_k = 0;
            m_pc = 0; m_addr = 0; m_tgt = 0;
        end else if (m_active) begin
            m_k++;
            if (m_k > F + 1) m_active = 0;
        end else if (!m_halt) begin
            trap = 0; take_iret = 0; spc = 0; saddr = 0;
            if (dtlb_miss) begin trap = 1; spc = mem_pc; saddr = dtlb_vaddr; end
            else if (iret_req && supervisor_mode) take_iret = 1;
            else if (itlb_miss) begin trap = 1; spc = if_pc; saddr = itlb_vaddr; end
            if (trap && supervisor_mode) m_halt = 1;
            else if (trap) begin
                m_active = 1; m_k = 1; m_is_iret = 0; m_pc = spc; m_addr = saddr; m_tgt = H;
            end else if (take_iret) begin
                m_active = 1; m_k = 1; m_is_iret = 1; m_tgt = epc_in;
            end
        end
    endtask

    task automatic compare_all();
        chk("tlb_miss", 32'(tlb_miss), 32'(m_active && !m_is_iret && m_k == 1));
        chk("iret", 32'(iret), 32'(m_active && m_is_iret && m_k == 1));
        chk("flush", 32'(flush), 32'(m_halt || (m_active && m_k <= F)));
        chk("pc_redirect", 32'(pc_redirect), 32'(m_active && m_k == F + 1));
        chk("busy", 32'(busy), 32'(m_halt || m_active));
        chk("halted", 32'(halted), 32'(m_halt));
        chk("tlb_pc", tlb_pc, m_pc);
        chk("tlb_addr", tlb_addr, m_addr);
        chk("pulse_excl", 32'(tlb_miss & iret), 32'd0);
        if (m_active && m_k == F + 1) chk("redirect_target", pc_redirect_target, m_tgt);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    vec_t vecs[$];

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(posedge clk);

        vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 0,0,0));
        vecs.push_back(mk(0, 1,0,0,0, 32'h410,32'h8000_0ABC,0,0,0, 1,0,1,0,1,0, 32'h410,32'h8000_0ABC,0));
        vecs.push_back(mk(0, 1,0,0,0, 32'h999,32'h1234_5678,0,0,0, 0,0,1,0,1,0, 32'h410,32'h8000_0ABC,0));
        vecs.push_back(mk(0, 1,0,0,0, 32'h999,32'h1234_5678,0,0,0, 0,0,1,0,1,0, 32'h410,32'h8000_0ABC,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,1,1,0, 32'h410,32'h8000_0ABC,H));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 32'h410,32'h8000_0ABC,0));
        vecs.push_back(mk(0, 1,1,1,0, 32'h500,32'h1111_0000,32'h600,32'h2222_0000,32'h77, 1,0,1,0,1,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,1,0,1,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,1,0,1,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,1,1,0, 32'h500,32'h1111_0000,H));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,1,1,1, 0,0,32'h700,32'h3333_0000,32'h104, 0,1,1,0,1,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,0,0,0,32'hFFFF_FFFF, 0,0,1,0,1,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,0,0,0,32'hFFFF_FFFF, 0,0,1,0,1,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,0,1, 0,0,0,0,32'hFFFF_FFFF, 0,0,0,1,1,0, 32'h500,32'h1111_0000,32'h104));
        vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0,0,0,0,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,1,0, 0,0,0,0,32'h55, 0,0,0,0,0,0, 32'h500,32'h1111_0000,0));
        vecs.push_back(mk(0, 0,0,1,0, 0,0,0,0,32'h55, 0,0,0,0,0,0, 32'h500,32'h1111_0000,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].dm, vecs[i].im, vecs[i].ir, vecs[i].sup,
                  vecs[i].mpc, vecs[i].dva, vecs[i].ipc, vecs[i].iva, vecs[i].epc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.tlb_miss", i), 32'(tlb_miss), 32'(vecs[i].e_tm));
            chk($sformatf("v%0d.iret", i), 32'(iret), 32'(vecs[i].e_ir));
            chk($sformatf("v%0d.flush", i), 32'(flush), 32'(vecs[i].e_fl));
            chk($sformatf("v%0d.pc_redirect", i), 32'(pc_redirect), 32'(vecs[i].e_rd));
            chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].e_bz));
            chk($sformatf("v%0d.halted", i), 32'(halted), 32'(vecs[i].e_ht));
            chk($sformatf("v%0d.tlb_pc", i), tlb_pc, vecs[i].e_pc);
            chk($sformatf("v%0d.tlb_addr", i), tlb_addr, vecs[i].e_addr);
            if (vecs[i].e_rd) chk($sformatf("v%0d.target", i), pc_redirect_target, vecs[i].e_tgt);
        end

        // FLUSH_CYCLES=1 instance: one flush cycle, redirect right after.
        drive(1, 0,0,0,0, 0,0,0,0,0); tick();
        drive(0, 1,0,0,0, 32'h40,32'h44,0,0,0); tick();
        chk("f1.tlb_miss", 32'(d1_tlb_miss), 32'd1);
        chk("f1.flush_on", 32'(d1_flush), 32'd1);
        chk("f1.tlb_addr", d1_tlb_addr, 32'h44);
        idle_inputs(); tick();
        chk("f1.flush_off", 32'(d1_flush), 32'd0);
        chk("f1.redirect", 32'(d1_pc_redirect), 32'd1);
        chk("f1.target", d1_target, H1);
        chk("f1.busy", 32'(d1_busy), 32'd1);
        tick();
        chk("f1.idle", 32'(d1_busy), 32'd0);
        chk("f1.redirect_off", 32'(d1_pc_redirect), 32'd0);
        repeat (3) tick();

        // Double fault: halt holds for 55+ cycles regardless of requests, reset clears.
        drive(0, 0,1,0,1, 0,0,32'h900,32'h9900,0); tick();
        chk("halt.entered", 32'(halted), 32'd1);
        for (int c = 0; c < 55; c++) begin
            drive(0, $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1), $urandom_range(0,1),
                  $urandom, $urandom, $urandom, $urandom, $urandom);
            tick();
        end
        drive(1, 0,0,0,0, 0,0,0,0,0); tick();
        chk("halt.cleared", 32'(halted), 32'd0);
        chk("halt.flush_cleared", 32'(flush), 32'd0);
        chk("halt.tlb_pc_zero", tlb_pc, 32'd0);

        // Reset mid-flush: nothing afterwards, then a fresh trap runs normally.
        idle_inputs(); tick();
        drive(0, 1,0,0,0, 32'hA0,32'hB0,0,0,0); tick();
        idle_inputs(); tick();
        reset = 1'b1; tick();
        chk("midrst.tlb_addr_zero", tlb_addr, 32'd0);
        chk("midrst.flush_zero", 32'(flush), 32'd0);
        idle_inputs();
        repeat (8) tick();
        drive(0, 0,1,0,0, 0,0,32'hC0,32'hD0,0); tick();
        chk("fresh.tlb_pc", tlb_pc, 32'hC0);
        idle_inputs();
        repeat (F + 2) tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0,59) == 0, $urandom_range(0,7) == 0, $urandom_range(0,7) == 0,
                  $urandom_range(0,5) == 0, $urandom_range(0,3) == 0,
                  $urandom, $urandom, $urandom, $urandom, $urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
